// File: rtl/double_adder_arbiter.sv
// double_adder_arbiter: shares a single double_adder between N_REQ clients.
// One client's operand pair is captured, pushed through the adder, and the
// result is handed back to that same client. Clients are served round-robin.

module double_adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 32,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ*64-1:0]   req_a,
  input  logic [N_REQ*64-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_stb,
  output logic [N_REQ-1:0]      req_ack,
  output logic [63:0]           rsp_z,
  output logic [N_REQ-1:0]      rsp_stb,
  input  logic [N_REQ-1:0]      rsp_ack,
  output logic [63:0]           adder_a,
  output logic [63:0]           adder_b,
  output logic                  adder_a_stb,
  output logic                  adder_b_stb,
  input  logic                  adder_a_ack,
  input  logic                  adder_b_ack,
  input  logic [63:0]           adder_z,
  input  logic                  adder_z_stb,
  output logic                  adder_z_ack,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_Z,
    S_ZACK,
    S_RETURN
  } state_t;

  // Registered state and outputs
  state_t             r_state;
  logic [ID_W-1:0]    r_last;
  logic [ID_W-1:0]    r_grant;
  logic [N_REQ-1:0]   r_reqAck;
  logic [N_REQ-1:0]   r_rspStb;
  logic [63:0]        r_rspZ;
  logic [63:0]        r_adderA;
  logic [63:0]        r_adderB;
  logic               r_aStb;
  logic               r_bStb;
  logic               r_zAck;
  logic               r_busy;
  logic [CNT_W-1:0]   r_opCount;

  // Next-state values
  state_t             w_stateNext;
  logic [ID_W-1:0]    w_lastNext;
  logic [ID_W-1:0]    w_grantNext;
  logic [N_REQ-1:0]   w_reqAckNext;
  logic [N_REQ-1:0]   w_rspStbNext;
  logic [63:0]        w_rspZNext;
  logic [63:0]        w_adderANext;
  logic [63:0]        w_adderBNext;
  logic               w_aStbNext;
  logic               w_bStbNext;
  logic               w_zAckNext;
  logic               w_busyNext;
  logic [CNT_W-1:0]   w_opCountNext;

  // Round-robin pick
  logic               w_found;
  logic [ID_W-1:0]    w_pick;
  logic [ID_W-1:0]    w_cand;
  logic [N_REQ-1:0]   w_pickOneHot;
  logic [N_REQ-1:0]   w_grantOneHot;

  assign w_pickOneHot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_grantOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;

  // Search requesters starting just after the last one served, wrapping around
  always_comb begin
    int sum;
    sum     = 0;
    w_cand  = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = int'(r_last) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      w_cand = ID_W'(sum);
      if (!w_found && req_stb[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a state moves it
  always_comb begin
    w_stateNext   = r_state;
    w_lastNext    = r_last;
    w_grantNext   = r_grant;
    w_reqAckNext  = '0;
    w_rspStbNext  = r_rspStb;
    w_rspZNext    = r_rspZ;
    w_adderANext  = r_adderA;
    w_adderBNext  = r_adderB;
    w_aStbNext    = r_aStb;
    w_bStbNext    = r_bStb;
    w_zAckNext    = r_zAck;
    w_opCountNext = r_opCount;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_adderANext = req_a[64*w_pick +: 64];
          w_adderBNext = req_b[64*w_pick +: 64];
          w_grantNext  = w_pick;
          w_reqAckNext = w_pickOneHot;
          w_aStbNext   = 1'b1;
          w_bStbNext   = 1'b1;
          w_stateNext  = S_SEND;
        end
      end
      S_SEND: begin
        w_aStbNext = r_aStb & ~adder_a_ack;
        w_bStbNext = r_bStb & ~adder_b_ack;
        if (!w_aStbNext && !w_bStbNext) begin
          w_stateNext = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        if (adder_z_stb) begin
          w_rspZNext  = adder_z;
          w_zAckNext  = 1'b1;
          w_stateNext = S_ZACK;
        end
      end
      S_ZACK: begin
        if (!adder_z_stb) begin
          w_zAckNext   = 1'b0;
          w_rspStbNext = w_grantOneHot;
          w_stateNext  = S_RETURN;
        end
      end
      S_RETURN: begin
        if (rsp_ack[r_grant]) begin
          w_rspStbNext  = '0;
          w_lastNext    = r_grant;
          w_opCountNext = r_opCount + CNT_W'(1);
          w_stateNext   = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    w_busyNext = (w_stateNext != S_IDLE);
  end

  // State and output registers with synchronous reset; last starts at N_REQ-1 so client 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= ID_W'(N_REQ - 1);
      r_grant   <= '0;
      r_reqAck  <= '0;
      r_rspStb  <= '0;
      r_rspZ    <= '0;
      r_adderA  <= '0;
      r_adderB  <= '0;
      r_aStb    <= 1'b0;
      r_bStb    <= 1'b0;
      r_zAck    <= 1'b0;
      r_busy    <= 1'b0;
      r_opCount <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_last    <= w_lastNext;
      r_grant   <= w_grantNext;
      r_reqAck  <= w_reqAckNext;
      r_rspStb  <= w_rspStbNext;
      r_rspZ    <= w_rspZNext;
      r_adderA  <= w_adderANext;
      r_adderB  <= w_adderBNext;
      r_aStb    <= w_aStbNext;
      r_bStb    <= w_bStbNext;
      r_zAck    <= w_zAckNext;
      r_busy    <= w_busyNext;
      r_opCount <= w_opCountNext;
    end
  end

  assign req_ack     = r_reqAck;
  assign rsp_stb     = r_rspStb;
  assign rsp_z       = r_rspZ;
  assign adder_a     = r_adderA;
  assign adder_b     = r_adderB;
  assign adder_a_stb = r_aStb;
  assign adder_b_stb = r_bStb;
  assign adder_z_ack = r_zAck;
  assign busy        = r_busy;
  assign grant_id    = r_grant;
  assign op_count    = r_opCount;

endmodule

// File: tb/tb_double_adder_arbiter.sv
// Testbench for double_adder_arbiter: a stub adder with adjustable ack and
// result latency, a scoreboard fed by a round-robin reference model, and a
// monitor that checks every response the arbiter returns.

module tb_double_adder_arbiter;

  localparam int N = 4;

  typedef struct {
    int          id;
    logic [63:0] z;
  } expItem_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*64-1:0]   req_a;
  logic [N*64-1:0]   req_b;
  logic [N-1:0]      req_stb;
  logic [N-1:0]      req_ack;
  logic [63:0]       rsp_z;
  logic [N-1:0]      rsp_stb;
  logic [N-1:0]      rsp_ack;
  logic [63:0]       adder_a;
  logic [63:0]       adder_b;
  logic              adder_a_stb;
  logic              adder_b_stb;
  logic              adder_a_ack;
  logic              adder_b_ack;
  logic [63:0]       adder_z;
  logic              adder_z_stb;
  logic              adder_z_ack;
  logic              busy;
  logic [1:0]        grant_id;
  logic [31:0]       op_count;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleNum = 0;

  int aDelay = 0;
  int bDelay = 0;
  int zLatency = 2;

  expItem_t    expQ[$];
  int          grantLog[$];
  int          aFallCycle = 0;
  int          bFallCycle = 0;
  int          rspHighCycles = 0;
  logic [63:0] lastRspZ = '0;

  logic [63:0] opA[N];
  logic [63:0] opB[N];
  int          modelLast = N - 1;
  int          modelCount = 0;

  double_adder_arbiter #(.N_REQ(N), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_a(req_a),
    .req_b(req_b),
    .req_stb(req_stb),
    .req_ack(req_ack),
    .rsp_z(rsp_z),
    .rsp_stb(rsp_stb),
    .rsp_ack(rsp_ack),
    .adder_a(adder_a),
    .adder_b(adder_b),
    .adder_a_stb(adder_a_stb),
    .adder_b_stb(adder_b_stb),
    .adder_a_ack(adder_a_ack),
    .adder_b_ack(adder_b_ack),
    .adder_z(adder_z),
    .adder_z_stb(adder_z_stb),
    .adder_z_ack(adder_z_ack),
    .busy(busy),
    .grant_id(grant_id),
    .op_count(op_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time strobe drops
  always @(posedge clk) cycleNum <= cycleNum + 1;

  function automatic logic [63:0] refAdd(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  // First requester in mask after 'last', wrapping modulo N
  function automatic int nextGrant(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [63:0] randOperand();
    return $realtobits(real'($urandom_range(1, 4000)) / 16.0);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Stub double_adder: acks each operand after its delay, then returns the sum after zLatency
  initial begin
    logic [63:0] stubA;
    logic [63:0] stubB;
    bit gotA;
    bit gotB;
    int aCnt;
    int bCnt;
    int zCnt;
    stubA = '0; stubB = '0; gotA = 0; gotB = 0; aCnt = 0; bCnt = 0; zCnt = 0;
    adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0; adder_z = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0; adder_z = '0;
        gotA = 0; gotB = 0; aCnt = 0; bCnt = 0; zCnt = 0;
      end else begin
        if (adder_a_ack) adder_a_ack = 1'b0;
        else if (adder_a_stb && !gotA) begin
          if (aCnt >= aDelay) begin
            adder_a_ack = 1'b1; stubA = adder_a; gotA = 1; aCnt = 0;
          end else aCnt++;
        end
        if (adder_b_ack) adder_b_ack = 1'b0;
        else if (adder_b_stb && !gotB) begin
          if (bCnt >= bDelay) begin
            adder_b_ack = 1'b1; stubB = adder_b; gotB = 1; bCnt = 0;
          end else bCnt++;
        end
        if (gotA && gotB && !adder_a_ack && !adder_b_ack) begin
          if (!adder_z_stb) begin
            if (zCnt >= zLatency) begin
              adder_z_stb = 1'b1; adder_z = refAdd(stubA, stubB);
            end else zCnt++;
          end else if (adder_z_ack) begin
            adder_z_stb = 1'b0; gotA = 0; gotB = 0; zCnt = 0;
          end
        end
      end
    end
  end

  // Monitor: checks grant pulses and pops the scoreboard whenever a response appears
  initial begin
    logic [N-1:0] prevRsp;
    logic [N-1:0] prevReqAck;
    logic [N-1:0] heldStb;
    logic [63:0]  heldZ;
    logic         prevA;
    logic         prevB;
    expItem_t     e;
    prevRsp = '0; prevReqAck = '0; heldStb = '0; heldZ = '0; prevA = 0; prevB = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevRsp = '0; prevReqAck = '0; prevA = 0; prevB = 0;
      end else begin
        if (req_ack != '0) begin
          checkOutput("reqAckOneHot", 64'($onehot(req_ack)), 64'd1);
          checkOutput("reqAckOneCycle", 64'(prevReqAck), 64'd0);
          for (int i = 0; i < N; i++) if (req_ack[i]) grantLog.push_back(i);
        end
        if (prevA && !adder_a_stb) aFallCycle = cycleNum;
        if (prevB && !adder_b_stb) bFallCycle = cycleNum;
        if (rsp_stb != '0) begin
          if (prevRsp == '0) begin
            rspHighCycles = 1;
            heldStb = rsp_stb;
            heldZ = rsp_z;
            lastRspZ = rsp_z;
            if (expQ.size() == 0) begin
              checkOutput("unexpectedRsp", 64'(rsp_stb), 64'd0);
            end else begin
              e = expQ.pop_front();
              checkOutput("rspStbId", 64'(rsp_stb), 64'd1 << e.id);
              checkOutput("rspZ", rsp_z, e.z);
              checkOutput("grantId", 64'(grant_id), 64'(e.id));
            end
          end else begin
            rspHighCycles++;
            checkOutput("rspStbStable", 64'(rsp_stb), 64'(heldStb));
            checkOutput("rspZStable", rsp_z, heldZ);
            checkOutput("busyInReturn", 64'(busy), 64'd1);
            checkOutput("noReqAckInReturn", 64'(req_ack), 64'd0);
          end
        end
        prevRsp = rsp_stb;
        prevReqAck = req_ack;
        prevA = adder_a_stb;
        prevB = adder_b_stb;
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_stb = '0;
    rsp_ack = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    grantLog.delete();
    modelLast = N - 1;
    modelCount = 0;
  endtask

  // Drive operands for masked clients, predict the service order, and raise their strobes
  task automatic applyStimulus(input logic [N-1:0] mask, input bit hold, input int nOps);
    logic [N-1:0] remaining;
    int g;
    expItem_t e;
    remaining = mask;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req_a[64*i +: 64] = opA[i];
        req_b[64*i +: 64] = opB[i];
      end
    end
    for (int n = 0; n < nOps; n++) begin
      g = nextGrant(modelLast, remaining);
      e.id = g;
      e.z = refAdd(opA[g], opB[g]);
      expQ.push_back(e);
      modelLast = g;
      modelCount++;
      if (!hold) remaining[g] = 1'b0;
    end
    req_stb = mask;
  endtask

  // Play requesters and consumers until nOps results have been accepted
  task automatic runUntilDone(input int nOps, input bit hold, input int rspDelay, input bit noise);
    int done;
    int cycles;
    int waitCnt;
    logic [N-1:0] prevStb;
    done = 0; cycles = 0; waitCnt = 0; prevStb = '0;
    while (done < nOps && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (!hold) req_stb = req_stb & ~req_ack;
      if (rsp_stb == '0) begin
        rsp_ack = '0;
        waitCnt = 0;
        if (prevStb != '0) done++;
      end else if (waitCnt >= rspDelay) begin
        rsp_ack = noise ? '1 : rsp_stb;
      end else begin
        waitCnt++;
        rsp_ack = noise ? ~rsp_stb : '0;
      end
      prevStb = rsp_stb;
    end
    req_stb = '0;
    rsp_ack = '0;
    if (done < nOps) checkOutput("opsCompletedBeforeTimeout", 64'(done), 64'(nOps));
  endtask

  // Main sequence
  initial begin
    int expOrder[$];
    int waited;
    logic [N-1:0] mask;
    rst = 1'b1;
    req_a = '0; req_b = '0; req_stb = '0; rsp_ack = '0;
    for (int i = 0; i < N; i++) begin opA[i] = '0; opB[i] = '0; end
    doReset();

    // Reset state
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetOpCount", 64'(op_count), 64'd0);
    checkOutput("resetGrantId", 64'(grant_id), 64'd0);
    checkOutput("resetStrobes", {58'd0, req_ack, adder_a_stb, adder_b_stb}, 64'd0);
    checkOutput("resetRsp", {rsp_z[63:4], rsp_stb | rsp_z[3:0]}, 64'd0);
    checkOutput("resetAdderOps", adder_a | adder_b, 64'd0);

    // Single op: 1.0 + 2.0 from requester 0
    opA[0] = 64'h3FF0000000000000;
    opB[0] = 64'h4000000000000000;
    applyStimulus(4'b0001, 1'b0, 1);
    runUntilDone(1, 1'b0, 0, 1'b0);
    checkOutput("singleOpZ", lastRspZ, 64'h4008000000000000);
    checkOutput("singleOpCount", 64'(op_count), 64'd1);

    // Contention with all requests held
    doReset();
    for (int i = 0; i < N; i++) begin opA[i] = randOperand(); opB[i] = randOperand(); end
    applyStimulus(4'b1111, 1'b1, 5);
    runUntilDone(5, 1'b1, 1, 1'b0);
    expOrder = '{0, 1, 2, 3, 0};
    checkOutput("contentionGrantCount", 64'(grantLog.size()), 64'd5);
    for (int i = 0; i < 5 && i < grantLog.size(); i++)
      checkOutput("contentionGrantOrder", 64'(grantLog[i]), 64'(expOrder[i]));
    checkOutput("contentionOpCount", 64'(op_count), 64'(modelCount));

    // Priority rotation after serving requester 2
    opA[2] = randOperand(); opB[2] = randOperand();
    applyStimulus(4'b0100, 1'b0, 1);
    runUntilDone(1, 1'b0, 0, 1'b0);
    grantLog.delete();
    for (int i = 0; i < N; i++) begin opA[i] = randOperand(); opB[i] = randOperand(); end
    applyStimulus(4'b1011, 1'b0, 3);
    runUntilDone(3, 1'b0, 0, 1'b0);
    expOrder = '{3, 0, 1};
    checkOutput("rotationGrantCount", 64'(grantLog.size()), 64'd3);
    for (int i = 0; i < 3 && i < grantLog.size(); i++)
      checkOutput("rotationGrantOrder", 64'(grantLog[i]), 64'(expOrder[i]));

    // Slow consumer with other requesters' acks toggling
    opA[1] = randOperand(); opB[1] = randOperand();
    applyStimulus(4'b0010, 1'b0, 1);
    runUntilDone(1, 1'b0, 20, 1'b1);
    checkOutput("slowConsumerHeld21", 64'(rspHighCycles >= 21), 64'd1);
    checkOutput("slowConsumerOpCount", 64'(op_count), 64'(modelCount));

    // Split operand acks: b acked three cycles after a
    aDelay = 0; bDelay = 3;
    opA[3] = randOperand(); opB[3] = randOperand();
    applyStimulus(4'b1000, 1'b0, 1);
    runUntilDone(1, 1'b0, 0, 1'b0);
    checkOutput("splitAckGap", 64'(bFallCycle - aFallCycle), 64'd3);
    aDelay = 0; bDelay = 0;

    // Reset while waiting for the adder result
    zLatency = 10;
    opA[0] = 64'h3FF0000000000000;
    opB[0] = 64'h4000000000000000;
    applyStimulus(4'b0001, 1'b0, 1);
    waited = 0;
    while (waited < 50) begin
      @(negedge clk);
      waited++;
      req_stb = req_stb & ~req_ack;
      if (busy && !adder_a_stb && !adder_b_stb && !adder_z_ack && rsp_stb == '0) break;
    end
    checkOutput("midOpWaitZReached", 64'(waited < 50), 64'd1);
    rst = 1'b1;
    req_stb = '0;
    @(negedge clk);
    checkOutput("midOpResetStrobes", {57'd0, req_ack, adder_a_stb, adder_b_stb, adder_z_ack}, 64'd0);
    checkOutput("midOpResetRspStb", 64'(rsp_stb), 64'd0);
    checkOutput("midOpResetBusy", 64'(busy), 64'd0);
    checkOutput("midOpResetOpCount", 64'(op_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    grantLog.delete();
    modelLast = N - 1;
    modelCount = 0;
    zLatency = 2;
    applyStimulus(4'b0001, 1'b0, 1);
    runUntilDone(1, 1'b0, 0, 1'b0);
    checkOutput("afterResetZ", lastRspZ, 64'h4008000000000000);
    checkOutput("afterResetOpCount", 64'(op_count), 64'd1);

    // Randomized batches with random latencies
    for (int it = 0; it < 8; it++) begin
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin opA[i] = randOperand(); opB[i] = randOperand(); end
      aDelay = $urandom_range(0, 3);
      bDelay = $urandom_range(0, 3);
      zLatency = $urandom_range(0, 5);
      applyStimulus(mask, 1'b0, $countones(mask));
      runUntilDone($countones(mask), 1'b0, $urandom_range(0, 3), 1'b0);
    end
    checkOutput("randomOpCount", 64'(op_count), 64'(modelCount));
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog in case the sequence itself stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got stall, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
